hazard_unit: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage MIPS core. Generates stall, flush and forwarding selects for the IF/ID, ID/EX and EX/MEM registers. Also runs a small FSM that holds a multi-cycle multiply/divide in EX for a fixed latency. It sits beside the pipeline registers and drives their enable and clear inputs, and the forwarding muxes.

---
 rtl/hazard_unit.sv | 142 ++++++++++++++
 tb/tb_hazard_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core: forwarding selects,
// load-use / branch / mult-div stalls and flushes, plus the mult/div hold FSM.
module hazard_unit #(
  parameter int MD_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs_D,
  input  logic [4:0] Rt_D,
  input  logic [4:0] Rs_E,
  input  logic [4:0] Rt_E,
  input  logic [4:0] WriteReg_E,
  input  logic [4:0] WriteReg_M,
  input  logic [4:0] WriteReg_W,
  input  logic       RegWrite_E,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  input  logic       MemtoReg_E,
  input  logic       MemtoReg_M,
  input  logic       Branch_D,
  input  logic       PCSrc_D,
  input  logic       MulDiv_E,
  output logic       Stall_F,
  output logic       Stall_D,
  output logic       Stall_E,
  output logic       Flush_D,
  output logic       Flush_E,
  output logic       Flush_M,
  output logic       ForwardA_D,
  output logic       ForwardB_D,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       MD_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MD_LATENCY - 3);

  md_state_t  state, state_next;
  logic [3:0] cnt, cnt_next;

  // $0 is hard-wired to zero, so it never constitutes a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel_e(input logic [4:0] src,
                                           input logic       wr_m,
                                           input logic [4:0] dst_m,
                                           input logic       wr_w,
                                           input logic [4:0] dst_w);
    if (wr_m && reg_match(dst_m, src))      return 2'b10;
    else if (wr_w && reg_match(dst_w, src)) return 2'b01;
    else                                    return 2'b00;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (avoids latches).
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: if (MulDiv_E) begin
        state_next = BUSY;
        cnt_next   = CNT_LOAD;
      end
      BUSY: if (cnt == 4'd0) state_next = DONE;
            else             cnt_next   = cnt - 4'd1;
      DONE: state_next = IDLE;
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  logic       lwstall, brstall, mdstall, any_stall;
  logic       fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;

  // Hazard detection
  always_comb begin
    lwstall = MemtoReg_E && (reg_match(WriteReg_E, Rs_D) || reg_match(WriteReg_E, Rt_D));
    brstall = Branch_D &&
              ((RegWrite_E && (reg_match(WriteReg_E, Rs_D) || reg_match(WriteReg_E, Rt_D))) ||
               (MemtoReg_M && (reg_match(WriteReg_M, Rs_D) || reg_match(WriteReg_M, Rt_D))));
    // DONE ignores MulDiv_E so the finishing op can leave EX without retriggering.
    mdstall   = ((state == IDLE) && MulDiv_E) || (state == BUSY);
    any_stall = lwstall || brstall || mdstall;
    fwd_a_d   = RegWrite_M && reg_match(WriteReg_M, Rs_D);
    fwd_b_d   = RegWrite_M && reg_match(WriteReg_M, Rt_D);
    fwd_a_e   = fwd_sel_e(Rs_E, RegWrite_M, WriteReg_M, RegWrite_W, WriteReg_W);
    fwd_b_e   = fwd_sel_e(Rt_E, RegWrite_M, WriteReg_M, RegWrite_W, WriteReg_W);
  end

  // Output logic; everything is held low while reset is asserted.
  always_comb begin
    Stall_F    = 1'b0;
    Stall_D    = 1'b0;
    Stall_E    = 1'b0;
    Flush_D    = 1'b0;
    Flush_E    = 1'b0;
    Flush_M    = 1'b0;
    ForwardA_D = 1'b0;
    ForwardB_D = 1'b0;
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    MD_busy    = 1'b0;
    if (rst_n) begin
      Stall_F    = any_stall;
      Stall_D    = any_stall;
      Stall_E    = mdstall;
      Flush_M    = mdstall;
      // A held EX stage must never be bubbled, so mdstall masks the flush.
      Flush_E    = (lwstall || brstall) && !mdstall;
      Flush_D    = PCSrc_D && !any_stall;
      ForwardA_D = fwd_a_d;
      ForwardB_D = fwd_b_d;
      ForwardA_E = fwd_a_e;
      ForwardB_E = fwd_b_e;
      MD_busy    = (state == BUSY);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MD_LATENCY = 4).
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
  logic       RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M;
  logic       Branch_D, PCSrc_D, MulDiv_E;
  logic       Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M;
  logic       ForwardA_D, ForwardB_D, MD_busy;
  logic [1:0] ForwardA_E, ForwardB_E;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MD_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
    .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M),
    .Branch_D(Branch_D), .PCSrc_D(PCSrc_D), .MulDiv_E(MulDiv_E),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M),
    .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .MD_busy(MD_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packs the stall/flush/busy outputs: {Stall_F,Stall_D,Stall_E,Flush_D,Flush_E,Flush_M,MD_busy}
  function automatic logic [31:0] ctl();
    return {25'd0, Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, MD_busy};
  endfunction

  task automatic clear_inputs();
    Rs_D = 0; Rt_D = 0; Rs_E = 0; Rt_E = 0;
    WriteReg_E = 0; WriteReg_M = 0; WriteReg_W = 0;
    RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
    MemtoReg_E = 0; MemtoReg_M = 0;
    Branch_D = 0; PCSrc_D = 0; MulDiv_E = 0;
  endtask

  // Advance to just after the next rising edge; inputs are then set and sampled before the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    RegWrite_M = 1; WriteReg_M = 8; Rs_E = 8; MulDiv_E = 1;
    #3;
    check("reset_ctl", ctl(), 32'h0);
    check("reset_fwdA_E", 32'(ForwardA_E), 32'h0);
    clear_inputs();
    next_cycle();
    rst_n = 1'b1;

    // Forwarding: MEM beats WB
    next_cycle();
    RegWrite_M = 1; WriteReg_M = 8; RegWrite_W = 1; WriteReg_W = 8; Rs_E = 8;
    #2 check("fwdA_E_mem_prio", 32'(ForwardA_E), 32'h2);
    WriteReg_M = 0; Rs_E = 0; WriteReg_W = 0;
    #2 check("fwdA_E_r0", 32'(ForwardA_E), 32'h0);
    WriteReg_M = 3; WriteReg_W = 7; Rt_E = 7; Rs_E = 3; Rs_D = 3; Rt_D = 7;
    #2 check("fwdB_E_wb", 32'(ForwardB_E), 32'h1);
    check("fwdA_E_mem", 32'(ForwardA_E), 32'h2);
    check("fwd_D", {30'd0, ForwardA_D, ForwardB_D}, 32'h2);
    check("fwd_no_stall", ctl(), 32'h0);

    // Load-use: 1 cycle stall + bubble, then clear
    next_cycle();
    clear_inputs();
    MemtoReg_E = 1; RegWrite_E = 1; WriteReg_E = 9; Rt_D = 9;
    #2 check("lwstall_c1", ctl(), 32'b1100100);
    next_cycle();
    clear_inputs();
    Rt_D = 9;
    #2 check("lwstall_c2", ctl(), 32'h0);

    // Taken branch without hazard flushes IF/ID
    next_cycle();
    clear_inputs();
    PCSrc_D = 1; Branch_D = 1; Rs_D = 4; Rt_D = 6;
    #2 check("branch_taken", ctl(), 32'b0001000);
    // Branch dependent on ALU result in EX: stall, no flush of IF/ID
    RegWrite_E = 1; WriteReg_E = 4;
    #2 check("brstall_ex", ctl(), 32'b1100100);
    // Producer is a load now in MEM: one more stall cycle
    next_cycle();
    RegWrite_E = 0; WriteReg_E = 0;
    MemtoReg_M = 1; RegWrite_M = 1; WriteReg_M = 4;
    #2 check("brstall_mem", ctl(), 32'b1100100);
    next_cycle();
    MemtoReg_M = 0; RegWrite_M = 0; WriteReg_M = 0; RegWrite_W = 1; WriteReg_W = 4;
    #2 check("branch_resolves", ctl(), 32'b0001000);

    // Mult/div sequence with MulDiv_E held
    next_cycle();
    clear_inputs();
    MulDiv_E = 1;
    #2 check("md_c1", ctl(), 32'b1110010);
    next_cycle();
    #2 check("md_c2", ctl(), 32'b1110011);
    next_cycle();
    #2 check("md_c3", ctl(), 32'b1110011);
    next_cycle();
    #2 check("md_c4_done", ctl(), 32'b0000000);
    next_cycle();
    MulDiv_E = 0;
    #2 check("md_c5_idle", ctl(), 32'b0000000);
    // Back-to-back: the next mult/div restarts from IDLE
    MulDiv_E = 1;
    #2 check("md_restart", ctl(), 32'b1110010);

    // Reset in BUSY aborts immediately
    next_cycle();
    #2 check("md_busy_pre_rst", 32'(MD_busy), 32'h1);
    RegWrite_M = 1; WriteReg_M = 2; Rs_E = 2; PCSrc_D = 1;
    rst_n = 1'b0;
    #1 check("rst_mid_ctl", ctl(), 32'h0);
    check("rst_mid_fwd", 32'(ForwardA_E), 32'h0);
    next_cycle();
    clear_inputs();
    rst_n = 1'b1;
    next_cycle();
    #2 check("post_rst_idle", ctl(), 32'h0);

    // Overlap of load-use and mult/div: mdstall governs
    MemtoReg_E = 1; RegWrite_E = 1; WriteReg_E = 9; Rt_D = 9; MulDiv_E = 1;
    #2 check("overlap_c1", ctl(), 32'b1110010);
    next_cycle();
    #2 check("overlap_c2", ctl(), 32'b1110011);
    next_cycle();
    next_cycle();
    // DONE: lwstall re-evaluated on its own
    #2 check("overlap_done", ctl(), 32'b1100100);
    next_cycle();
    clear_inputs();
    #2 check("overlap_idle", ctl(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
